// File: rtl/bus_slave_mem_if.sv
// Bus connection between the arbitrated master data path and the RAM slave:
// address/data phase inputs from the master side, response signals back to it.
interface bus_slave_mem_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              hsel;
   logic              trans;
   logic [ADDR_W-1:0] addr;
   logic              write;
   logic              master_id;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic [1:0]        resp;
   logic [1:0]        split_mask;

   modport master (
      output hsel, trans, addr, write, master_id, wdata, busy,
      input  rdata, ready, resp, split_mask
   );

   modport slave (
      input  hsel, trans, addr, write, master_id, wdata, busy,
      output rdata, ready, resp, split_mask
   );
endinterface

// File: rtl/bus_slave_mem.sv
// Word-addressed RAM slave with pipelined address/data phases, configurable wait
// states, two-cycle ERROR/SPLIT/RETRY responses and a delayed split release pulse.
module bus_slave_mem #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int OFFS_W       = 12,
   parameter int DEPTH        = 256,
   parameter int WAIT_STATES  = 1,
   parameter int SPLIT_CYCLES = 8
) (
   input logic             clk,
   input logic             rst,
   bus_slave_mem_if.slave  bus
);

   localparam int IDX_W  = OFFS_W - 2;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WCNT_W = 4;
   localparam int SCNT_W = (SPLIT_CYCLES > 1) ? $clog2(SPLIT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_ERR1, S_ERR2, S_SPL1, S_SPL2, S_RTY1, S_RTY2
   } state_t;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01,
      RESP_RETRY = 2'b10,
      RESP_SPLIT = 2'b11
   } resp_t;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                pend_q, pend_d;      // OKAY data phase completes in IDLE
   logic [MEM_AW-1:0]   idx_q;
   logic                write_q;
   logic                id_q;
   logic [DATA_W-1:0]   rdata_q;

   logic                split_pend_q;
   logic                split_arm_q;
   logic [SCNT_W-1:0]   split_cnt_q;
   logic                split_id_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                ready_int;
   resp_t               resp_int;
   resp_t               cls;
   logic                accept;
   logic                done;
   logic                rd_done;
   logic [IDX_W-1:0]    idx_full;
   logic [31:0]         idx_wide;
   logic                misaligned;
   logic                out_of_range;
   logic                unused_addr_hi;

   // Region decode above OFFS_W is done upstream; those bits are intentionally ignored.
   assign unused_addr_hi = ^bus.addr[ADDR_W-1:OFFS_W];

   assign idx_full     = bus.addr[OFFS_W-1:2];
   assign idx_wide     = 32'(idx_full);
   assign misaligned   = |bus.addr[1:0];
   assign out_of_range = idx_wide >= 32'(DEPTH);

   assign accept  = ready_int && bus.hsel && bus.trans;
   assign done    = (state_q == S_IDLE) && pend_q;
   assign rd_done = done && !write_q;

   // Classification of the transfer being sampled, highest priority first.
   always_comb begin
      cls = RESP_OKAY;
      if (misaligned || out_of_range) begin
         cls = RESP_ERROR;
      end else if (bus.busy && split_pend_q) begin
         cls = RESP_RETRY;
      end else if (bus.busy) begin
         cls = RESP_SPLIT;
      end
   end

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      pend_d    = pend_q;
      ready_int = 1'b1;
      resp_int  = RESP_OKAY;

      unique case (state_q)
         S_WAIT: begin
            ready_int = 1'b0;
            if (wcnt_q == '0) begin
               state_d = S_IDLE;
               pend_d  = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         S_ERR1: begin
            ready_int = 1'b0;
            resp_int  = RESP_ERROR;
            state_d   = S_ERR2;
         end
         S_ERR2: resp_int = RESP_ERROR;
         S_SPL1: begin
            ready_int = 1'b0;
            resp_int  = RESP_SPLIT;
            state_d   = S_SPL2;
         end
         S_SPL2: resp_int = RESP_SPLIT;
         S_RTY1: begin
            ready_int = 1'b0;
            resp_int  = RESP_RETRY;
            state_d   = S_RTY2;
         end
         S_RTY2: resp_int = RESP_RETRY;
         default: ;
      endcase

      // Any ready=1 cycle ends the current data phase and may start the next one.
      if (ready_int) begin
         pend_d  = 1'b0;
         state_d = S_IDLE;
         if (accept) begin
            unique case (cls)
               RESP_OKAY: begin
                  if (WAIT_STATES > 0) begin
                     state_d = S_WAIT;
                     wcnt_d  = WCNT_W'(WAIT_STATES - 1);
                  end else begin
                     pend_d = 1'b1;
                  end
               end
               RESP_ERROR: state_d = S_ERR1;
               RESP_SPLIT: state_d = S_SPL1;
               RESP_RETRY: state_d = S_RTY1;
               default:    ;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         pend_q  <= 1'b0;
         idx_q   <= '0;
         write_q <= 1'b0;
         id_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         pend_q  <= pend_d;
         if (accept) begin
            idx_q   <= idx_full[MEM_AW-1:0];
            write_q <= bus.write;
            id_q    <= bus.master_id;
         end
         if (rd_done) begin
            rdata_q <= mem[idx_q];
         end
      end
   end

   // NOTE: the RAM array has no reset; only the write enable is gated by rst,
   // so a reset during a transfer aborts it without touching stored contents.
   always_ff @(posedge clk) begin
      if (!rst && done && write_q) begin
         mem[idx_q] <= bus.wdata;
      end
   end

   // Split bookkeeping: pending from SPLIT sample until the release pulse;
   // the countdown starts when the second SPLIT response cycle ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         split_pend_q <= 1'b0;
         split_arm_q  <= 1'b0;
         split_cnt_q  <= '0;
         split_id_q   <= 1'b0;
      end else begin
         if (accept && cls == RESP_SPLIT) begin
            split_pend_q <= 1'b1;
         end
         if (state_q == S_SPL2) begin
            split_arm_q <= 1'b1;
            split_cnt_q <= SCNT_W'(SPLIT_CYCLES - 1);
            split_id_q  <= id_q;
         end else if (split_arm_q) begin
            if (split_cnt_q == '0) begin
               split_arm_q  <= 1'b0;
               split_pend_q <= 1'b0;
            end else begin
               split_cnt_q <= split_cnt_q - 1'b1;
            end
         end
      end
   end

   assign bus.split_mask = (split_arm_q && split_cnt_q == '0) ? (2'b01 << split_id_q) : 2'b00;
   assign bus.ready      = ready_int;
   assign bus.resp       = resp_int;
   assign bus.rdata      = rd_done ? mem[idx_q] : rdata_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench for bus_slave_mem: dut1 runs with one wait state, dut0 with none.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_bus_slave_mem;

   localparam int AW        = 16;
   localparam int DW        = 32;
   localparam int SPLIT_CYC = 8;

   localparam logic [1:0] OKAY  = 2'b00;
   localparam logic [1:0] ERROR = 2'b01;
   localparam logic [1:0] RETRY = 2'b10;
   localparam logic [1:0] SPLIT = 2'b11;

   typedef struct {
      int          inst;
      logic [1:0]  resp;
      logic [31:0] rdata;
      bit          chk_rd;
      int          waits;
      logic        id;
   } exp_t;

   typedef struct {
      int          inst;
      int          due;
      logic [1:0]  mask;
   } spl_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   exp_t sb[$];
   spl_t sq[$];

   logic          hsel_v [2];
   logic          trans_v[2];
   logic          write_v[2];
   logic          id_v   [2];
   logic          busy_v [2];
   logic [AW-1:0] addr_v [2];
   logic [DW-1:0] wdata_v[2];

   logic          rdy  [2];
   logic [1:0]    rsp  [2];
   logic [1:0]    smask[2];
   logic [DW-1:0] rdat [2];

   bit outst[2];
   int lows [2];

   bus_slave_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   bus_slave_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   assign bus0.hsel      = hsel_v[0];
   assign bus0.trans     = trans_v[0];
   assign bus0.addr      = addr_v[0];
   assign bus0.write     = write_v[0];
   assign bus0.master_id = id_v[0];
   assign bus0.wdata     = wdata_v[0];
   assign bus0.busy      = busy_v[0];
   assign bus1.hsel      = hsel_v[1];
   assign bus1.trans     = trans_v[1];
   assign bus1.addr      = addr_v[1];
   assign bus1.write     = write_v[1];
   assign bus1.master_id = id_v[1];
   assign bus1.wdata     = wdata_v[1];
   assign bus1.busy      = busy_v[1];

   assign rdy[0]   = bus0.ready;
   assign rsp[0]   = bus0.resp;
   assign smask[0] = bus0.split_mask;
   assign rdat[0]  = bus0.rdata;
   assign rdy[1]   = bus1.ready;
   assign rsp[1]   = bus1.resp;
   assign smask[1] = bus1.split_mask;
   assign rdat[1]  = bus1.rdata;

   bus_slave_mem #(.WAIT_STATES(0), .SPLIT_CYCLES(SPLIT_CYC)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   bus_slave_mem #(.WAIT_STATES(1), .SPLIT_CYCLES(SPLIT_CYC)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int find_exp(input int i);
      for (int k = 0; k < sb.size(); k++) begin
         if (sb[k].inst == i) return k;
      end
      return -1;
   endfunction

   task automatic mon_step(input int i);
      int k;
      if (rst) begin
         outst[i] = 1'b0;
         lows[i]  = 0;
         return;
      end
      if (outst[i]) begin
         k = find_exp(i);
         if (k < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_phase[%0d]: data phase with empty scoreboard (cycle %0d)", i, cyc);
            outst[i] = 1'b0;
         end else if (!rdy[i]) begin
            lows[i]++;
            check($sformatf("resp_wait[%0d]", i), 32'(rsp[i]), 32'(sb[k].resp));
         end else begin
            check($sformatf("resp[%0d]", i), 32'(rsp[i]), 32'(sb[k].resp));
            check($sformatf("wait_cycles[%0d]", i), 32'(lows[i]), 32'(sb[k].waits));
            if (sb[k].chk_rd) check($sformatf("rdata[%0d]", i), rdat[i], sb[k].rdata);
            if (sb[k].resp == SPLIT) sq.push_back('{i, cyc + SPLIT_CYC, 2'b01 << sb[k].id});
            sb.delete(k);
            outst[i] = 1'b0;
            lows[i]  = 0;
         end
      end else begin
         check($sformatf("idle_ready[%0d]", i), 32'(rdy[i]), 32'd1);
         check($sformatf("idle_resp[%0d]", i), 32'(rsp[i]), 32'(OKAY));
      end
      if (rdy[i] && hsel_v[i] && trans_v[i]) outst[i] = 1'b1;
   endtask

   task automatic spl_step(input int i);
      logic [1:0] e;
      int         k;
      e = 2'b00;
      k = -1;
      if (rst) return;
      foreach (sq[j]) begin
         if (sq[j].inst == i && sq[j].due == cyc) k = j;
      end
      if (k >= 0) begin
         e = sq[k].mask;
         sq.delete(k);
      end
      check($sformatf("split_mask[%0d]", i), 32'(smask[i]), 32'(e));
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mon_step(i);
         spl_step(i);
      end
   end

   // Present one address phase, wait for it to be sampled, then enter its data phase.
   task automatic issue(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                        input logic id, input logic bsy, input logic [1:0] er, input logic [DW-1:0] erd);
      exp_t e;
      int   n;
      e.inst   = i;
      e.resp   = er;
      e.rdata  = erd;
      e.chk_rd = (!wr && er == OKAY);
      e.waits  = (er == OKAY) ? ((i == 1) ? 1 : 0) : 1;
      e.id     = id;
      sb.push_back(e);
      hsel_v[i]  = 1'b1;
      trans_v[i] = 1'b1;
      addr_v[i]  = a;
      write_v[i] = wr;
      id_v[i]    = id;
      busy_v[i]  = bsy;
      n = 0;
      @(negedge clk);
      while (!rdy[i]) begin
         n++;
         if (n > 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout[%0d]: ready stayed low for %0d cycles", i, n);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      wdata_v[i] = wd;
      hsel_v[i]  = 1'b0;
      trans_v[i] = 1'b0;
      busy_v[i]  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         hsel_v[i]  = 1'b0;
         trans_v[i] = 1'b0;
         write_v[i] = 1'b0;
         id_v[i]    = 1'b0;
         busy_v[i]  = 1'b0;
         addr_v[i]  = '0;
         wdata_v[i] = '0;
         outst[i]   = 1'b0;
         lows[i]    = 0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_rdata[%0d]", i), rdat[i], 32'd0);
         check($sformatf("reset_ready[%0d]", i), 32'(rdy[i]), 32'd1);
      end
      @(posedge clk);
      #1;

      // One wait state: write then read back.
      issue(1, 16'h0000, 1'b1, 32'hA5A5_0000, 1'b0, 1'b0, OKAY, 32'h0);
      issue(1, 16'h0008, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, OKAY, 32'h0);
      issue(1, 16'h0008, 1'b0, 32'h0,         1'b0, 1'b0, OKAY, 32'hDEAD_BEEF);

      // Zero wait states: four back-to-back pipelined transfers.
      issue(0, 16'h0010, 1'b1, 32'd567, 1'b0, 1'b0, OKAY, 32'h0);
      issue(0, 16'h0014, 1'b1, 32'd434, 1'b0, 1'b0, OKAY, 32'h0);
      issue(0, 16'h0010, 1'b0, 32'h0,   1'b0, 1'b0, OKAY, 32'd567);
      issue(0, 16'h0014, 1'b0, 32'h0,   1'b0, 1'b0, OKAY, 32'd434);

      // Unaligned and out-of-range accesses, then confirm RAM untouched.
      issue(1, 16'h0402, 1'b0, 32'h0,         1'b0, 1'b0, ERROR, 32'h0);
      issue(1, 16'h0400, 1'b0, 32'h0,         1'b0, 1'b0, ERROR, 32'h0);
      issue(1, 16'h0400, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, ERROR, 32'h0);
      issue(1, 16'h000A, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, ERROR, 32'h0);
      issue(1, 16'h0000, 1'b0, 32'h0,         1'b0, 1'b0, OKAY,  32'hA5A5_0000);
      issue(1, 16'h0008, 1'b0, 32'h0,         1'b0, 1'b0, OKAY,  32'hDEAD_BEEF);

      // Split for master2, retry for master1 while pending, then a normal read.
      issue(1, 16'h0008, 1'b0, 32'h0, 1'b1, 1'b1, SPLIT, 32'h0);
      issue(1, 16'h0004, 1'b0, 32'h0, 1'b0, 1'b1, RETRY, 32'h0);
      issue(1, 16'h0008, 1'b0, 32'h0, 1'b0, 1'b0, OKAY,  32'hDEAD_BEEF);
      repeat (14) @(posedge clk);
      #1;

      // Reset during the wait state of a write must leave prior contents.
      issue(1, 16'h0020, 1'b1, 32'h1111_1111, 1'b0, 1'b0, OKAY, 32'h0);
      issue(1, 16'h0020, 1'b1, 32'h2222_2222, 1'b0, 1'b0, OKAY, 32'h0);
      rst = 1'b1;
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].inst == 1) sb.delete(k);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      issue(1, 16'h0020, 1'b0, 32'h0, 1'b0, 1'b0, OKAY, 32'h1111_1111);

      // Zero-wait error followed by a pipelined read.
      issue(0, 16'h0FFC, 1'b0, 32'h0, 1'b0, 1'b0, ERROR, 32'h0);
      issue(0, 16'h0014, 1'b0, 32'h0, 1'b0, 1'b0, OKAY,  32'd434);

      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
      check("split_drain", 32'(sq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
